// File: rtl/main_ctrl_pkg.sv
// Shared encodings for the multicycle ARM main controller: states, mux selects,
// opcode classes and the decoded control word.
package main_ctrl_pkg;

   localparam int unsigned STATE_ENC_W = 4;

   typedef enum logic [STATE_ENC_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_e;

   localparam logic [1:0] SRCA_REG   = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;

   localparam logic [1:0] SRCB_WD    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] OP_DP      = 2'b00;
   localparam logic [1:0] OP_MEM     = 2'b01;
   localparam logic [1:0] OP_BR      = 2'b10;
   localparam logic [1:0] OP_UNDEF   = 2'b11;

   // Raw per-state control word; irwrite/nextpc are still ungated by mem_ready.
   typedef struct packed {
      logic       irwrite;
      logic       nextpc;
      logic       branch;
      logic       regw;
      logic       memw;
      logic       adrsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] resultsrc;
      logic       aluop;
   } ctrl_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// Purely combinational state -> control-word decoder; unknown encodings give all zeros.
module main_fsm_outdec
   import main_ctrl_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic [STATE_W-1:0] state_i,
   output ctrl_t              ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         STATE_W'(S_FETCH): begin
            ctrl_o.irwrite   = 1'b1;
            ctrl_o.nextpc    = 1'b1;
            ctrl_o.alusrca   = SRCA_PC;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.resultsrc = RES_ALURES;
         end
         STATE_W'(S_DECODE): begin
            ctrl_o.alusrca   = SRCA_PC;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.resultsrc = RES_ALURES;
         end
         STATE_W'(S_MEMADR): begin
            ctrl_o.alusrca   = SRCA_REG;
            ctrl_o.alusrcb   = SRCB_IMM;
         end
         STATE_W'(S_MEMRD): begin
            ctrl_o.adrsrc    = 1'b1;
            ctrl_o.resultsrc = RES_ALUOUT;
         end
         STATE_W'(S_MEMWB): begin
            ctrl_o.resultsrc = RES_DATA;
            ctrl_o.regw      = 1'b1;
         end
         STATE_W'(S_MEMWR): begin
            ctrl_o.adrsrc    = 1'b1;
            ctrl_o.memw      = 1'b1;
         end
         STATE_W'(S_EXECUTER): begin
            ctrl_o.alusrca   = SRCA_REG;
            ctrl_o.alusrcb   = SRCB_WD;
            ctrl_o.aluop     = 1'b1;
         end
         STATE_W'(S_EXECUTEI): begin
            ctrl_o.alusrca   = SRCA_REG;
            ctrl_o.alusrcb   = SRCB_IMM;
            ctrl_o.aluop     = 1'b1;
         end
         STATE_W'(S_ALUWB): begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.regw      = 1'b1;
         end
         STATE_W'(S_BRANCH): begin
            ctrl_o.alusrca   = SRCA_REG;
            ctrl_o.alusrcb   = SRCB_IMM;
            ctrl_o.resultsrc = RES_ALURES;
            ctrl_o.branch    = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle ARM main controller: state register, next-state logic and
// mem_ready/reset gating of the decoded control word.
module main_fsm
   import main_ctrl_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       mem_ready,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       Branch,
   output logic       RegW,
   output logic       MemW,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       ALUOp,
   output logic       illegal_op
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic [STATE_W-1:0] dec_state;
   ctrl_t              ctrl;
   logic [3:0]         unused_funct;

   assign unused_funct = Funct[4:1];

   always_ff @(posedge clk) begin
      if (reset) state_q <= STATE_W'(S_FETCH);
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = STATE_W'(S_FETCH);
      case (state_q)
         STATE_W'(S_FETCH):    state_d = mem_ready ? STATE_W'(S_DECODE) : state_q;
         STATE_W'(S_DECODE): begin
            case (Op)
               OP_MEM:  state_d = STATE_W'(S_MEMADR);
               OP_DP:   state_d = Funct[5] ? STATE_W'(S_EXECUTEI) : STATE_W'(S_EXECUTER);
               OP_BR:   state_d = STATE_W'(S_BRANCH);
               default: state_d = STATE_W'(S_FETCH);
            endcase
         end
         STATE_W'(S_MEMADR):   state_d = Funct[0] ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
         STATE_W'(S_MEMRD):    state_d = mem_ready ? STATE_W'(S_MEMWB) : state_q;
         STATE_W'(S_MEMWB):    state_d = STATE_W'(S_FETCH);
         STATE_W'(S_MEMWR):    state_d = mem_ready ? STATE_W'(S_FETCH) : state_q;
         STATE_W'(S_EXECUTER): state_d = STATE_W'(S_ALUWB);
         STATE_W'(S_EXECUTEI): state_d = STATE_W'(S_ALUWB);
         STATE_W'(S_ALUWB):    state_d = STATE_W'(S_FETCH);
         STATE_W'(S_BRANCH):   state_d = STATE_W'(S_FETCH);
         default:              state_d = STATE_W'(S_FETCH);
      endcase
   end

   // Reset presents the FETCH selects; the only FETCH strobes are then masked below.
   assign dec_state = reset ? STATE_W'(S_FETCH) : state_q;

   main_fsm_outdec #(
      .STATE_W (STATE_W)
   ) u_outdec (
      .state_i (dec_state),
      .ctrl_o  (ctrl)
   );

   assign IRWrite    = ctrl.irwrite & mem_ready & ~reset;
   assign NextPC     = ctrl.nextpc  & mem_ready & ~reset;
   assign Branch     = ctrl.branch;
   assign RegW       = ctrl.regw;
   assign MemW       = ctrl.memw;
   assign AdrSrc     = ctrl.adrsrc;
   assign ALUSrcA    = ctrl.alusrca;
   assign ALUSrcB    = ctrl.alusrcb;
   assign ResultSrc  = ctrl.resultsrc;
   assign ALUOp      = ctrl.aluop;
   assign illegal_op = ~reset & (state_q == STATE_W'(S_DECODE)) & (Op == OP_UNDEF);

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: directed per-cycle vectors push expected control
// words; a negedge monitor pops and compares them against the DUT outputs.
module tb_main_fsm;

   typedef enum int {
      T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB,
      T_MEMWR, T_EXECUTER, T_EXECUTEI, T_ALUWB, T_BRANCH
   } tst_e;

   typedef struct {
      logic [14:0] v;
      int          idx;
      tst_e        st;
   } rec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       mem_ready;
   logic       IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUOp, illegal_op;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

   rec_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   step_idx = 0;

   always #5 clk = ~clk;

   main_fsm #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct      (Funct),
      .mem_ready  (mem_ready),
      .IRWrite    (IRWrite),
      .NextPC     (NextPC),
      .Branch     (Branch),
      .RegW       (RegW),
      .MemW       (MemW),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ALUOp      (ALUOp),
      .illegal_op (illegal_op)
   );

   // Hand table of the per-state control word {IRWrite,NextPC,Branch,RegW,MemW,AdrSrc,SrcA,SrcB,Result,ALUOp,illegal}.
   function automatic logic [14:0] exp_cw(input tst_e st, input logic mr, input logic rst, input logic ill);
      logic irw, npc, br, rw, mw, adr, aop;
      logic [1:0] a, b, r;
      tst_e s;
      irw = 0; npc = 0; br = 0; rw = 0; mw = 0; adr = 0; aop = 0;
      a = 2'b00; b = 2'b00; r = 2'b00;
      s = rst ? T_FETCH : st;
      case (s)
         T_FETCH:    begin a = 2'b01; b = 2'b10; r = 2'b10; irw = mr; npc = mr; end
         T_DECODE:   begin a = 2'b01; b = 2'b10; r = 2'b10; end
         T_MEMADR:   begin b = 2'b01; end
         T_MEMRD:    begin adr = 1; end
         T_MEMWB:    begin r = 2'b01; rw = 1; end
         T_MEMWR:    begin adr = 1; mw = 1; end
         T_EXECUTER: begin aop = 1; end
         T_EXECUTEI: begin b = 2'b01; aop = 1; end
         T_ALUWB:    begin rw = 1; end
         T_BRANCH:   begin b = 2'b01; r = 2'b10; br = 1; end
         default:    ;
      endcase
      if (rst) begin irw = 0; npc = 0; end
      return {irw, npc, br, rw, mw, adr, a, b, r, aop, ill & ~rst};
   endfunction

   // Drive one cycle's inputs just after the edge and record what that cycle must show.
   task automatic step(input tst_e st, input logic mr, input logic [1:0] op,
                       input logic [5:0] fn, input logic rst, input logic ill);
      rec_t r;
      reset = rst; mem_ready = mr; Op = op; Funct = fn;
      r.v = exp_cw(st, mr, rst, ill);
      r.idx = step_idx;
      r.st = st;
      sb.push_back(r);
      step_idx++;
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      rec_t r;
      logic [14:0] got;
      #2;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            r = sb.pop_front();
            got = {IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal_op};
            total++;
            if (got !== r.v) begin
               bad++;
               $display("FAIL step=%0d state=%s got=%b expected=%b", r.idx, r.st.name(), got, r.v);
            end
         end
      end
   end

   initial begin : stim
      reset = 1'b1; mem_ready = 1'b1; Op = 2'b00; Funct = 6'b0;
      @(posedge clk);
      #1;
      // Reset with mem_ready high: strobes stay low, selects show FETCH.
      step(T_FETCH, 1, 2'b00, 6'b000000, 1, 0);
      step(T_FETCH, 1, 2'b00, 6'b000000, 1, 0);
      // ADD register
      step(T_FETCH,    1, 2'b00, 6'b001000, 0, 0);
      step(T_DECODE,   1, 2'b00, 6'b001000, 0, 0);
      step(T_EXECUTER, 1, 2'b00, 6'b001000, 0, 0);
      step(T_ALUWB,    1, 2'b00, 6'b001000, 0, 0);
      // LDR with two wait cycles; Op changes in MEMRD must be ignored
      step(T_FETCH,  1, 2'b01, 6'b011001, 0, 0);
      step(T_DECODE, 1, 2'b01, 6'b011001, 0, 0);
      step(T_MEMADR, 1, 2'b01, 6'b011001, 0, 0);
      step(T_MEMRD,  0, 2'b11, 6'b011001, 0, 0);
      step(T_MEMRD,  0, 2'b11, 6'b000000, 0, 0);
      step(T_MEMRD,  1, 2'b10, 6'b000000, 0, 0);
      step(T_MEMWB,  1, 2'b11, 6'b000000, 0, 0);
      // STR with one wait cycle
      step(T_FETCH,  1, 2'b01, 6'b011000, 0, 0);
      step(T_DECODE, 1, 2'b01, 6'b011000, 0, 0);
      step(T_MEMADR, 1, 2'b01, 6'b011000, 0, 0);
      step(T_MEMWR,  0, 2'b01, 6'b011000, 0, 0);
      step(T_MEMWR,  1, 2'b01, 6'b011000, 0, 0);
      // B
      step(T_FETCH,  1, 2'b10, 6'b000000, 0, 0);
      step(T_DECODE, 1, 2'b10, 6'b000000, 0, 0);
      step(T_BRANCH, 1, 2'b10, 6'b000000, 0, 0);
      // Data-processing immediate
      step(T_FETCH,    1, 2'b00, 6'b101000, 0, 0);
      step(T_DECODE,   1, 2'b00, 6'b101000, 0, 0);
      step(T_EXECUTEI, 1, 2'b00, 6'b101000, 0, 0);
      step(T_ALUWB,    1, 2'b00, 6'b101000, 0, 0);
      // FETCH stalled 3 cycles, then undefined Op in DECODE
      step(T_FETCH,  0, 2'b11, 6'b000000, 0, 0);
      step(T_FETCH,  0, 2'b11, 6'b000000, 0, 0);
      step(T_FETCH,  0, 2'b11, 6'b000000, 0, 0);
      step(T_FETCH,  1, 2'b11, 6'b000000, 0, 0);
      step(T_DECODE, 1, 2'b11, 6'b000000, 0, 1);
      // Reset asserted while a store waits on memory
      step(T_FETCH,  1, 2'b01, 6'b000000, 0, 0);
      step(T_DECODE, 1, 2'b01, 6'b000000, 0, 0);
      step(T_MEMADR, 1, 2'b01, 6'b000000, 0, 0);
      step(T_MEMWR,  0, 2'b01, 6'b000000, 0, 0);
      step(T_MEMWR,  0, 2'b01, 6'b000000, 1, 0);
      step(T_FETCH,  1, 2'b10, 6'b000000, 0, 0);
      step(T_DECODE, 1, 2'b10, 6'b000000, 0, 0);
      step(T_BRANCH, 1, 2'b10, 6'b000000, 0, 0);
      step(T_FETCH,  0, 2'b00, 6'b000000, 0, 0);
      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
